// File: rtl/odd_change_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : odd_change_pkg
//  Description : Shared helpers for the odd-ratio 50% duty-cycle divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package odd_change_pkg;

    // A division ratio is usable only when it is odd and at least 3.
    function automatic bit div_is_legal(input int n);
        return (n >= 3) && ((n % 2) == 1);
    endfunction

endpackage : odd_change_pkg
`default_nettype wire

// File: rtl/mod_n_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mod_n_counter
//  Description : Wrap-around counter 0..MOD-1 with synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int MOD = 5,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_last = W'(MOD - 1);

    // Count up each rising edge, wrapping from MOD-1 back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == c_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : mod_n_counter
`default_nettype wire

// File: rtl/odd_change.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : odd_change
//  Description : Divides clk by an odd ratio DIV_N with exact 50% duty cycle.
//                A posedge flag is high for (DIV_N-1)/2 cycles; OR-ing it with
//                a half-cycle-delayed copy stretches the high time by half a
//                clock, giving DIV_N/2 cycles high and DIV_N/2 cycles low.
//  Revision    : 1.0 - initial release
// ============================================================================
module odd_change
    import odd_change_pkg::*;
#(
    parameter int DIV_N = 5
) (
    input  logic clk,
    input  logic rst,
    output logic dout
);

    localparam int                 CNT_W    = $clog2(DIV_N);
    localparam logic [CNT_W-1:0]   HIGH_CNT = CNT_W'((DIV_N - 1) / 2);

    // Reject even or too-small ratios while elaborating.
    if (!div_is_legal(DIV_N)) begin : g_bad_div
        $error("odd_change: DIV_N=%0d is illegal, must be odd and >= 3", DIV_N);
    end

    logic [CNT_W-1:0] w_cnt_p;
    logic             r_q_p;
    logic             r_q_n;

    mod_n_counter #(
        .MOD (DIV_N),
        .W   (CNT_W)
    ) u_cnt_p (
        .clk (clk),
        .rst (rst),
        .cnt (w_cnt_p)
    );

    // Posedge flag: high while the pre-update count is in the first half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_p <= 1'b0;
        end else begin
            r_q_p <= (w_cnt_p < HIGH_CNT);
        end
    end

    // Negedge copy of the posedge flag, delayed by half a clock period.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_q_n <= 1'b0;
        end else begin
            r_q_n <= r_q_p;
        end
    end

    // Output is a pure OR of the two flops; the overlap hides the hand-off.
    assign dout = r_q_p | r_q_n;

endmodule : odd_change
`default_nettype wire

// File: tb/tb_odd_change.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_odd_change
//  Description : Directed self-checking bench for odd_change at DIV_N=3,5,7.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_change;

    logic clk;
    logic rst;
    logic dout3;
    logic dout5;
    logic dout7;

    int   n_checks = 0;
    int   n_err    = 0;

    logic mon_en    = 1'b0;
    logic have_last = 1'b0;
    longint last_t  = 0;
    int   n_edges   = 0;
    longint t_p0    = 0;

    odd_change #(.DIV_N(5)) dut5 (.clk(clk), .rst(rst), .dout(dout5));
    odd_change #(.DIV_N(3)) dut3 (.clk(clk), .rst(rst), .dout(dout3));
    odd_change #(.DIV_N(7)) dut7 (.clk(clk), .rst(rst), .dout(dout7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every dout5 edge must be 25 ns after the previous one.
    always @(dout5) begin
        if (mon_en) begin
            if (have_last)
                check("d5_half_period", 32'($time - last_t), 32'd25);
            have_last = 1'b1;
            last_t    = $time;
            n_edges++;
        end
    end

    // Sample every half clock starting at the first posedge after release.
    // Half-slot k: dout high when (k mod 2N) < N; cnt5 after posedge j is (j+1)%5.
    task automatic run_slots(input int n, input string ph);
        for (int k = 0; k < n; k++) begin
            @(clk);
            #1;
            if (k == 0) t_p0 = $time - 1;
            check($sformatf("%s_d5_%0d", ph, k), {31'd0, dout5}, 32'((k % 10) < 5));
            check($sformatf("%s_d3_%0d", ph, k), {31'd0, dout3}, 32'((k % 6) < 3));
            check($sformatf("%s_d7_%0d", ph, k), {31'd0, dout7}, 32'((k % 14) < 7));
            if ((k % 2) == 0)
                check($sformatf("%s_cnt5_%0d", ph, k), 32'(dut5.w_cnt_p), 32'(((k / 2) + 1) % 5));
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        // Reset held across posedges at 5, 15, 25 ns; output must stay low.
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_d5_%0d", i), {31'd0, dout5}, 32'd0);
            check($sformatf("rst_d3_%0d", i), {31'd0, dout3}, 32'd0);
            check($sformatf("rst_d7_%0d", i), {31'd0, dout7}, 32'd0);
            @(clk);
            #1;
        end
        check("rst_cnt5", 32'(dut5.w_cnt_p), 32'd0);

        // Release just after a falling edge; next posedge is the first rise.
        rst       = 1'b0;
        have_last = 1'b0;
        n_edges   = 0;
        mon_en    = 1'b1;
        run_slots(42, "run");

        // Free-run to 100 full periods from the first rise.
        while ($time < t_p0 + 4990) @(posedge clk);
        mon_en = 1'b0;
        check("d5_edge_count", 32'(n_edges), 32'd200);

        // Find a point just after a falling edge while dout5 is high.
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(clk);
            #1;
            if (clk == 1'b0 && dout5 == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("pulse_found_high", {31'd0, found}, 32'd1);

        // One-cycle reset pulse aborts the pulse by the next falling edge.
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("pulse_d5_low", {31'd0, dout5}, 32'd0);
        check("pulse_d3_low", {31'd0, dout3}, 32'd0);
        check("pulse_d7_low", {31'd0, dout7}, 32'd0);
        rst = 1'b0;
        run_slots(28, "rel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_odd_change
`default_nettype wire

// File: doc/odd_change.md
ODD_CHANGE -- requirements
Module: odd_change

Interface
REQ-001 Parameter DIV_N, default 5: odd division ratio; legal values are odd integers >= 3.
REQ-002 Parameter CNT_W, default $clog2(DIV_N): width of the internal counter; derived, not overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes occur on its edges.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port dout, output, 1 bit: clk divided by DIV_N with exactly 50% duty cycle.

Function
REQ-006 The design SHALL hold a posedge counter cnt_p (CNT_W bits) stepping 0,1,...,DIV_N-1 and wrapping to 0 on each rising clk edge with rst=0.
REQ-007 A posedge flag q_p SHALL be loaded each rising edge with rst=0 as (cnt_p < (DIV_N-1)/2), using the pre-update cnt_p.
- q_p is therefore high for (DIV_N-1)/2 clk cycles and low for (DIV_N+1)/2 cycles per period.
REQ-008 A negedge flag q_n SHALL capture q_p on every falling clk edge with rst=0, delaying q_p by half a clk period.
REQ-009 dout SHALL equal q_p OR q_n, driven combinationally from the two flops, with no other logic in the output path.
REQ-010 dout SHALL have period DIV_N clk cycles and a high time of exactly DIV_N/2 clk cycles.
- Example: for DIV_N=5, dout is high for 2.5 cycles and low for 2.5 cycles.
REQ-011 The first dout rising edge SHALL coincide with the first rising clk edge that samples rst=0.
REQ-012 The counter wrap from DIV_N-1 to 0 SHALL not produce any glitch or extra edge on dout.
REQ-013 An illegal DIV_N (even, or less than 3) SHALL cause an elaboration-time error.

Reset
REQ-014 A rising clk edge with rst=1 SHALL clear cnt_p to 0 and q_p to 0.
REQ-015 A falling clk edge with rst=1 SHALL clear q_n to 0.
REQ-016 dout SHALL be 0 from the first falling edge within a reset assertion until reset is released.
REQ-017 Reset asserted mid-period SHALL abort the current output cycle.
- After release, dout restarts from the REQ-011 phase with no residual partial pulse.
REQ-018 dout is 0 from time zero only after reset has been applied; behaviour before the first reset is not defined.

Structure
REQ-019 No shared package is required.
- DIV_N and the derived constants (CNT_W, HIGH_CNT=(DIV_N-1)/2) are module-local localparams.
REQ-020 One sub-module is natural: mod_n_counter, a parameterised wrap-around counter with synchronous reset, instantiated once for cnt_p.
REQ-021 The negedge flop SHALL be the only negative-edge logic in the block.
REQ-022 The block SHALL contain no latches and no derived clocks used as flop clocks.

Verification
REQ-023 DIV_N=5, clk period 10 ns, rst=1 for 3 cycles: dout=0 throughout reset.
- dout rises at the first posedge after release, falls 25 ns later, and rises again 50 ns after the first rise.
REQ-024 DIV_N=5, free-run 100 periods: every high time is 25 ns, every low time is 25 ns, and the dout edge count is 200.
REQ-025 DIV_N=3: high time is 15 ns and period is 30 ns.
- DIV_N=7: high time is 35 ns and period is 70 ns.
REQ-026 DIV_N=5, rst pulsed for 1 cycle while dout is high: dout=0 by the next falling edge.
- After release, the first rise is exactly at the first posedge sampling rst=0, followed by a full 25 ns high time.
REQ-027 DIV_N=4: elaboration fails with an error message.
REQ-028 Monitor cnt_p across 2 periods for DIV_N=5: sequence is 0,1,2,3,4,0,...
- q_p is high only after the edges that sampled cnt_p=0 or 1.
